sn_window_decoder: RTL and testbench

//   Stochastic-to-binary decoding stage, downstream of the bipolar XNOR multiplier.
//   - Counts 1s in a serial bipolar SN bitstream over a power-of-two window.
//   - Converts each count to a normalised unsigned value and a signed bipolar value.
//   - Optionally smooths the bipolar value with an exponential moving average (EMA).
//   - Presents results through a one-entry valid/ready output register.

---
 rtl/sn_window_if.sv | 25 ++
 rtl/sn_window_decoder.sv | 144 ++++++++++++++
 tb/tb_sn_window_decoder.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sn_window_if.sv
// Result and bitstream bundle for the stochastic window decoder.
// The decoder (slave) consumes the bitstream and drives the result side.
interface sn_window_if #(
  parameter int CNT_W = 8
);
  logic             sn_valid;
  logic             sn_bit;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_count;
  logic [CNT_W-1:0] res_unorm;
  logic [CNT_W-1:0] res_bipolar;
  logic [CNT_W-1:0] res_avg;
  logic             ovf;

  modport master (
    output sn_valid, sn_bit, res_ready,
    input  res_valid, res_count, res_unorm, res_bipolar, res_avg, ovf
  );

  modport slave (
    input  sn_valid, sn_bit, res_ready,
    output res_valid, res_count, res_unorm, res_bipolar, res_avg, ovf
  );
endinterface

// File: rtl/sn_window_decoder.sv
// Counts 1s of a bipolar SN bitstream over 2^k-beat windows and emits count/unorm/bipolar.
// Optional EMA smoothing of the bipolar value is built when SN_DECODE_EMA_EN is defined.
module sn_window_decoder #(
  parameter int CNT_W     = 8,
  parameter int AVG_SHIFT = 2
) (
  input  logic          clk,
  input  logic          rst_n,     // asynchronous, active-high despite the name
  input  logic          en,
  input  logic [2:0]    win_log2,
  sn_window_if.slave    sn
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HALF = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [2:0]       K_MAX = 3'(CNT_W - 1);

  state_t           state_q;
  logic [2:0]       k_q;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] one_cnt;

  logic             res_valid_q;
  logic [CNT_W-1:0] res_count_q;
  logic [CNT_W-1:0] res_unorm_q;
  logic [CNT_W-1:0] res_bipolar_q;
  logic             ovf_q;

  logic [2:0]       k_in;
  logic [CNT_W-1:0] win_last;
  logic [CNT_W-1:0] count_final;
  logic [CNT_W:0]   unorm_wide;
  logic [CNT_W-1:0] unorm_sat;
  logic [CNT_W-1:0] bipolar;
  logic             win_close;
  logic             drop;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    k_in        = (int'(win_log2) > CNT_W - 1) ? K_MAX : win_log2;
    win_last    = CNT_W'((32'd1 << k_q) - 32'd1);
    count_final = one_cnt + CNT_W'(sn.sn_bit);
    unorm_wide  = {1'b0, count_final} << (CNT_W - int'(k_q));
    unorm_sat   = unorm_wide[CNT_W] ? '1 : unorm_wide[CNT_W-1:0];
    bipolar     = unorm_sat - HALF;
    win_close   = (state_q == ST_ACCUM) && en && sn.sn_valid && (beat_cnt == win_last);
    drop        = win_close && res_valid_q && !sn.res_ready;
  end

`ifdef SN_DECODE_EMA_EN
  logic [CNT_W-1:0]        avg_q;
  logic signed [CNT_W:0]   ema_diff;
  logic signed [CNT_W:0]   ema_step;
  logic [CNT_W-1:0]        avg_next;

  // Sign-extend both operands so the difference never wraps before the shift.
  always_comb begin
    ema_diff = $signed({bipolar[CNT_W-1], bipolar}) - $signed({avg_q[CNT_W-1], avg_q});
    ema_step = ema_diff >>> AVG_SHIFT;
    avg_next = avg_q + ema_step[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      avg_q <= '0;
    end else if (win_close && !drop) begin
      avg_q <= avg_next;
    end
  end

  assign sn.res_avg = avg_q;
`else
  assign sn.res_avg = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q       <= ST_IDLE;
      k_q           <= '0;
      beat_cnt      <= '0;
      one_cnt       <= '0;
      res_valid_q   <= 1'b0;
      res_count_q   <= '0;
      res_unorm_q   <= '0;
      res_bipolar_q <= '0;
      ovf_q         <= 1'b0;
    end else begin
      if (res_valid_q && sn.res_ready) begin
        res_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_q  <= ST_ACCUM;
            k_q      <= k_in;
            beat_cnt <= '0;
            one_cnt  <= '0;
          end
        end

        ST_ACCUM: begin
          if (!en) begin
            state_q  <= ST_IDLE;
            beat_cnt <= '0;
            one_cnt  <= '0;
          end else if (sn.sn_valid) begin
            if (win_close) begin
              beat_cnt <= '0;
              one_cnt  <= '0;
              k_q      <= k_in;
              if (drop) begin
                ovf_q <= 1'b1;
              end else begin
                // A close always wins over a same-cycle handshake: the new result replaces it.
                res_valid_q   <= 1'b1;
                res_count_q   <= count_final;
                res_unorm_q   <= unorm_sat;
                res_bipolar_q <= bipolar;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              one_cnt  <= count_final;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sn.res_valid   = res_valid_q;
  assign sn.res_count   = res_count_q;
  assign sn.res_unorm   = res_unorm_q;
  assign sn.res_bipolar = res_bipolar_q;
  assign sn.ovf         = ovf_q;

endmodule

// File: tb/tb_sn_window_decoder.sv
// Randomised self-checking bench for sn_window_decoder against a window-level reference model.
// The EMA expectations follow SN_DECODE_EMA_EN in the same way as the design.
module tb_sn_window_decoder;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic       valid;
    logic [7:0] count;
    logic [7:0] unorm;
    logic [7:0] bipolar;
    logic [7:0] avg;
    logic       ovf;
  } res_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] win_log2;

  sn_window_if #(.CNT_W(CNT_W)) sn ();

  sn_window_decoder #(.CNT_W(CNT_W), .AVG_SHIFT(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .win_log2 (win_log2),
    .sn       (sn.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: window contents held as a queue of bits.
  bit   m_active;
  int   m_k;
  bit   m_bits[$];
  bit   m_valid;
  int   m_count, m_unorm, m_bip, m_avg;
  bit   m_ovf;

  function automatic res_t obs();
    return {sn.res_valid, sn.res_count, sn.res_unorm, sn.res_bipolar, sn.res_avg, sn.ovf};
  endfunction

  function automatic res_t mdl();
    return {m_valid, 8'(m_count), 8'(m_unorm), 8'(m_bip), 8'(m_avg), m_ovf};
  endfunction

  function automatic int clamp_k(input logic [2:0] k);
    return (int'(k) > CNT_W - 1) ? CNT_W - 1 : int'(k);
  endfunction

  task automatic model_reset();
    m_active = 0; m_k = 0; m_bits.delete();
    m_valid = 0; m_count = 0; m_unorm = 0; m_bip = 0; m_avg = 0; m_ovf = 0;
  endtask

  task automatic model_edge();
    bit take;
    bit loaded;
    int c;
    take   = m_valid && sn.res_ready;
    loaded = 0;
    if (!m_active) begin
      if (en) begin
        m_active = 1;
        m_k = clamp_k(win_log2);
        m_bits.delete();
      end
    end else if (!en) begin
      m_active = 0;
      m_bits.delete();
    end else if (sn.sn_valid) begin
      m_bits.push_back(sn.sn_bit);
      if (m_bits.size() == (1 << m_k)) begin
        if (m_valid && !sn.res_ready) begin
          m_ovf = 1;
        end else begin
          c = 0;
          foreach (m_bits[i]) c += int'(m_bits[i]);
          m_count = c;
          m_unorm = c * (1 << (CNT_W - m_k));
          if (m_unorm > 255) m_unorm = 255;
          m_bip = m_unorm - 128;
`ifdef SN_DECODE_EMA_EN
          m_avg = m_avg + ((m_bip - m_avg) >>> 2);
`endif
          loaded = 1;
        end
        m_bits.delete();
        m_k = clamp_k(win_log2);
      end
    end
    if (loaded) m_valid = 1;
    else if (take) m_valid = 0;
  endtask

  // One clock: drive inputs away from the edge, advance the model at the edge, settle.
  task automatic cycle(input logic e, input logic v, input logic b, input logic rdy);
    en = e; sn.sn_valid = v; sn.sn_bit = b; sn.res_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    #2;
    model_reset();
    checks++;
    if (obs() !== res_t'(0)) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs(), res_t'(0));
    end
    rst_n = 1'b0;
    en = 1'b0; sn.sn_valid = 1'b0; sn.sn_bit = 1'b0; sn.res_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b0; win_log2 = 3'd0;
    sn.sn_valid = 1'b0; sn.sn_bit = 1'b0; sn.res_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_saturate();
    do_reset();
    win_log2 = 3'd3;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1, 1, 1, 0);
    checks++;
    if (obs() !== mdl()) begin
      errors++; $display("FAIL sat_model: got %h expected %h", obs(), mdl());
    end
    checks++;
    if (sn.res_count !== 8'd8 || sn.res_unorm !== 8'd255 || sn.res_bipolar !== 8'd127) begin
      errors++;
      $display("FAIL sat_const: got %0d/%0d/%0d expected 8/255/127",
               sn.res_count, sn.res_unorm, sn.res_bipolar);
    end
    cycle(1, 0, 0, 1);
    checks++;
    if (sn.res_valid !== 1'b0) begin
      errors++; $display("FAIL sat_consume: got valid %b expected 0", sn.res_valid);
    end
  endtask

  task automatic test_zero_half();
    do_reset();
    win_log2 = 3'd3;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0);
    checks++;
    if (sn.res_valid !== 1'b1 || sn.res_count !== 8'd0 || sn.res_unorm !== 8'd0 ||
        sn.res_bipolar !== 8'h80) begin
      errors++;
      $display("FAIL zero_const: got %b %0d/%0d/%h expected 1 0/0/80",
               sn.res_valid, sn.res_count, sn.res_unorm, sn.res_bipolar);
    end
    do_reset();
    win_log2 = 3'd2;
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 0); cycle(1, 1, 0, 0); cycle(1, 1, 1, 0); cycle(1, 1, 0, 0);
    checks++;
    if (sn.res_count !== 8'd2 || sn.res_unorm !== 8'd128 || sn.res_bipolar !== 8'd0) begin
      errors++;
      $display("FAIL half_const: got %0d/%0d/%0d expected 2/128/0",
               sn.res_count, sn.res_unorm, sn.res_bipolar);
    end
    checks++;
    if (obs() !== mdl()) begin
      errors++; $display("FAIL half_model: got %h expected %h", obs(), mdl());
    end
  endtask

  task automatic test_gaps();
    do_reset();
    win_log2 = 3'd2;
    cycle(1, 0, 0, 1);
    for (int w = 0; w < 6; w++) begin
      for (int b = 0; b < 4; b++) begin
        int gap = $urandom_range(3, 0);
        for (int g = 0; g < gap; g++) begin
          cycle(1, 0, 1'($urandom), 1);
          checks++;
          if (obs() !== mdl()) begin
            errors++; $display("FAIL gap_idle: got %h expected %h", obs(), mdl());
          end
        end
        cycle(1, 1, 1'($urandom), 1);
        checks++;
        if (obs() !== mdl()) begin
          errors++; $display("FAIL gap_beat: got %h expected %h", obs(), mdl());
        end
        if (b == 3) begin
          checks++;
          if (sn.res_valid !== 1'b1) begin
            errors++; $display("FAIL gap_latency: got valid %b expected 1", sn.res_valid);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    res_t first;
    do_reset();
    win_log2 = 3'd2;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 1'($urandom), 0);
    first = obs();
    checks++;
    if (first !== mdl()) begin
      errors++; $display("FAIL bp_first: got %h expected %h", first, mdl());
    end
    for (int i = 0; i < 4; i++) cycle(1, 1, 1'($urandom), 0);
    checks++;
    if (obs() !== mdl() || sn.ovf !== 1'b1) begin
      errors++; $display("FAIL bp_drop: got %h expected %h", obs(), mdl());
    end
    checks++;
    if (obs().count !== first.count || sn.res_valid !== 1'b1) begin
      errors++; $display("FAIL bp_hold: got %0d expected %0d", obs().count, first.count);
    end
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    checks++;
    if (sn.res_valid !== 1'b0 || sn.ovf !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got valid %b ovf %b expected 0 1", sn.res_valid, sn.ovf);
    end
  endtask

  task automatic test_abort();
    int ones;
    bit b;
    do_reset();
    win_log2 = 3'd3;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 1, 0);
    cycle(0, 1, 1, 0);
    cycle(1, 0, 0, 0);
    checks++;
    if (sn.res_valid !== 1'b0) begin
      errors++; $display("FAIL abort_noresult: got valid %b expected 0", sn.res_valid);
    end
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      b = 1'($urandom);
      ones += int'(b);
      cycle(1, 1, b, 0);
    end
    checks++;
    if (sn.res_count !== 8'(ones) || obs() !== mdl()) begin
      errors++; $display("FAIL abort_count: got %0d expected %0d", sn.res_count, ones);
    end
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0);
    cycle(0, 0, 0, 0);
    checks++;
    if (obs() !== mdl() || sn.res_valid !== 1'b1) begin
      errors++; $display("FAIL abort_keep: got %h expected %h", obs(), mdl());
    end
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 0);
    do_reset();
  endtask

  task automatic test_k_bounds();
    do_reset();
    win_log2 = 3'd0;
    cycle(1, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      bit b = 1'($urandom);
      cycle(1, 1, b, 1);
      checks++;
      if (sn.res_count !== 8'(b) || obs() !== mdl()) begin
        errors++; $display("FAIL k0_beat: got %h expected %h", obs(), mdl());
      end
    end
    do_reset();
    win_log2 = 3'd7;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 128; i++) cycle(1, 1, 1, 0);
    checks++;
    if (sn.res_count !== 8'd128 || sn.res_unorm !== 8'd255 || sn.res_bipolar !== 8'd127) begin
      errors++;
      $display("FAIL k7_sat: got %0d/%0d/%0d expected 128/255/127",
               sn.res_count, sn.res_unorm, sn.res_bipolar);
    end
  endtask

  task automatic test_ema();
    int exp_avg[3];
`ifdef SN_DECODE_EMA_EN
    exp_avg = '{16, 28, 37};
`else
    exp_avg = '{0, 0, 0};
`endif
    do_reset();
    win_log2 = 3'd2;
    cycle(1, 0, 0, 1);
    for (int w = 0; w < 3; w++) begin
      cycle(1, 1, 1, 1); cycle(1, 1, 1, 1); cycle(1, 1, 1, 1); cycle(1, 1, 0, 1);
      checks++;
      if (sn.res_bipolar !== 8'd64 || sn.res_avg !== 8'(exp_avg[w])) begin
        errors++;
        $display("FAIL ema_window%0d: got bip %0d avg %0d expected 64 %0d",
                 w, sn.res_bipolar, sn.res_avg, exp_avg[w]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    win_log2 = 3'($urandom_range(3, 0));
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(9, 0) == 0) win_log2 = 3'($urandom_range(3, 0));
      cycle($urandom_range(30, 0) != 0, $urandom_range(9, 0) < 7,
            1'($urandom), $urandom_range(9, 0) < 5);
      checks++;
      if (obs() !== mdl()) begin
        errors++; $display("FAIL random_cycle%0d: got %h expected %h", i, obs(), mdl());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_saturate();
    test_zero_half();
    test_gaps();
    test_backpressure();
    test_abort();
    test_k_bounds();
    test_ema();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
